// File: rtl/inst_mem_arbiter.sv
// Arbitrates the single-port code memory between the CPU fetch path and the
// host program loader, sequencing hold / drain / load / PC-reset / release.
module inst_mem_arbiter #(
    parameter int CODE_ADDR_WIDTH = 10,
    parameter int CODE_DATA_WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_req,
    input  logic                       load_wr_en,
    input  logic [CODE_ADDR_WIDTH-1:0] load_wr_addr,
    input  logic [CODE_DATA_WIDTH-1:0] load_wr_data,
    output logic                       load_gnt,
    output logic                       load_err,
    input  logic                       cpu_rd_en,
    input  logic [CODE_ADDR_WIDTH-1:0] cpu_rd_addr,
    input  logic                       cpu_halted,
    output logic                       cpu_hold,
    output logic                       pc_rst,
    output logic                       code_ready,
    output logic [CODE_ADDR_WIDTH:0]   prog_len,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [CODE_ADDR_WIDTH-1:0] mem_addr,
    output logic [CODE_DATA_WIDTH-1:0] mem_wdata
);

    typedef enum logic [2:0] {
        S_NOPROG,
        S_RUN,
        S_DRAIN,
        S_LOAD,
        S_SETTLE
    } state_t;

    localparam logic [CODE_ADDR_WIDTH:0] WORDS_MAX = {1'b1, {CODE_ADDR_WIDTH{1'b0}}};
    localparam logic [CODE_ADDR_WIDTH:0] ONE       = {{CODE_ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                     state_q, state_d;
    logic [CODE_ADDR_WIDTH:0]   count_q, count_d;
    logic [CODE_ADDR_WIDTH:0]   prog_len_q, prog_len_d;
    logic                       code_ready_q, code_ready_d;
    logic                       load_err_q, load_err_d;
    logic [CODE_ADDR_WIDTH:0]   count_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_NOPROG;
            count_q      <= '0;
            prog_len_q   <= '0;
            code_ready_q <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            prog_len_q   <= prog_len_d;
            code_ready_q <= code_ready_d;
            load_err_q   <= load_err_d;
        end
    end

    // Word count including this cycle's write, so a write coinciding with the
    // fall of load_req is still counted.
    assign count_inc = (load_wr_en && (count_q != WORDS_MAX)) ? count_q + ONE : count_q;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        prog_len_d   = prog_len_q;
        code_ready_d = code_ready_q;
        load_err_d   = load_wr_en && (state_q != S_LOAD);
        case (state_q)
            S_NOPROG: begin
                code_ready_d = 1'b0;
                if (load_req) begin
                    state_d = S_LOAD;
                    count_d = '0;
                end
            end
            S_RUN: begin
                if (load_req) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cpu_halted) begin
                    state_d      = S_LOAD;
                    count_d      = '0;
                    code_ready_d = 1'b0;
                end
            end
            S_LOAD: begin
                count_d = count_inc;
                if (!load_req) begin
                    if (count_inc == '0) begin
                        state_d = S_NOPROG;
                    end else begin
                        state_d    = S_SETTLE;
                        prog_len_d = count_inc;
                    end
                end
            end
            S_SETTLE: begin
                state_d      = S_RUN;
                code_ready_d = 1'b1;
            end
            default: state_d = S_NOPROG;
        endcase
    end

    assign load_gnt   = (state_q == S_LOAD);
    assign cpu_hold   = (state_q != S_RUN);
    assign pc_rst     = (state_q == S_SETTLE);
    assign code_ready = code_ready_q;
    assign prog_len   = prog_len_q;
    assign load_err   = load_err_q;

    // DRAIN keeps the CPU on the port so an in-flight packet can finish fetching.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_RUN, S_DRAIN: begin
                mem_en   = cpu_rd_en;
                mem_addr = cpu_rd_addr;
            end
            S_LOAD: begin
                mem_en    = load_wr_en;
                mem_we    = load_wr_en;
                mem_addr  = load_wr_addr;
                mem_wdata = load_wr_data;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Directed and randomized bench for inst_mem_arbiter against a phase-level
// reference model of the reprogramming sequence.
module tb_inst_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam int MAXW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_req, load_wr_en;
    logic [AW-1:0] load_wr_addr;
    logic [DW-1:0] load_wr_data;
    logic          load_gnt, load_err;
    logic          cpu_rd_en;
    logic [AW-1:0] cpu_rd_addr;
    logic          cpu_halted;
    logic          cpu_hold, pc_rst, code_ready;
    logic [AW:0]   prog_len;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    inst_mem_arbiter #(.CODE_ADDR_WIDTH(AW), .CODE_DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .load_req(load_req), .load_wr_en(load_wr_en),
        .load_wr_addr(load_wr_addr), .load_wr_data(load_wr_data),
        .load_gnt(load_gnt), .load_err(load_err),
        .cpu_rd_en(cpu_rd_en), .cpu_rd_addr(cpu_rd_addr), .cpu_halted(cpu_halted),
        .cpu_hold(cpu_hold), .pc_rst(pc_rst), .code_ready(code_ready),
        .prog_len(prog_len),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: which party owns the port and where the reload is.
    bit m_running, m_draining, m_loading, m_settling;
    bit m_ready, m_err;
    int m_words, m_len;

    int we_seen, pcrst_seen, err_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_running = 0; m_draining = 0; m_loading = 0; m_settling = 0;
            m_ready = 0; m_err = 0; m_words = 0; m_len = 0;
        end else begin
            m_err = load_wr_en && !m_loading;
            if (m_loading) begin
                m_words = m_words + int'(load_wr_en);
                if (m_words > MAXW) m_words = MAXW;
                if (!load_req) begin
                    m_loading = 0;
                    if (m_words > 0) begin
                        m_settling = 1;
                        m_len = m_words;
                    end
                end
            end else if (m_settling) begin
                m_settling = 0;
                m_running = 1;
                m_ready = 1;
            end else if (m_draining) begin
                if (cpu_halted) begin
                    m_draining = 0;
                    m_loading = 1;
                    m_words = 0;
                    m_ready = 0;
                end
            end else if (m_running) begin
                if (load_req) begin
                    m_running = 0;
                    m_draining = 1;
                end
            end else if (load_req) begin
                m_loading = 1;
                m_words = 0;
            end
        end
    endtask

    task automatic check_outputs();
        bit cpu_own;
        logic [63:0] e_en, e_we, e_addr, e_wdata;
        cpu_own = m_running || m_draining;
        e_en    = cpu_own ? 64'(cpu_rd_en) : (m_loading ? 64'(load_wr_en) : 64'd0);
        e_we    = 64'(m_loading && load_wr_en);
        e_addr  = cpu_own ? 64'(cpu_rd_addr) : (m_loading ? 64'(load_wr_addr) : 64'd0);
        e_wdata = m_loading ? 64'(load_wr_data) : 64'd0;
        chk("load_gnt",   64'(load_gnt),   64'(m_loading));
        chk("load_err",   64'(load_err),   64'(m_err));
        chk("cpu_hold",   64'(cpu_hold),   64'(!m_running));
        chk("pc_rst",     64'(pc_rst),     64'(m_settling));
        chk("code_ready", 64'(code_ready), 64'(m_ready));
        chk("prog_len",   64'(prog_len),   64'(m_len));
        chk("mem_en",     64'(mem_en),     e_en);
        chk("mem_we",     64'(mem_we),     e_we);
        chk("mem_addr",   64'(mem_addr),   e_addr);
        chk("mem_wdata",  64'(mem_wdata),  e_wdata);
        if (mem_we) we_seen++;
        if (pc_rst) pcrst_seen++;
        if (load_err) err_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] data);
        load_wr_en   = 1'b1;
        load_wr_addr = AW'(addr);
        load_wr_data = data;
        tick();
        load_wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_req = 0; load_wr_en = 0; load_wr_addr = '0; load_wr_data = '0;
        cpu_rd_en = 0; cpu_rd_addr = '0; cpu_halted = 0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // First load from NOPROG: four words, then release.
        we_seen = 0; pcrst_seen = 0;
        load_req = 1'b1;
        tick();
        chk("gnt_after_1", 64'(load_gnt), 64'd1);
        for (int i = 0; i < 4; i++) wr(i, DW'(8'hA0 + i));
        load_req = 1'b0;
        tick(); tick();
        chk("first_we_cnt", 64'(we_seen), 64'd4);
        chk("first_pcrst_cnt", 64'(pcrst_seen), 64'd1);
        chk("first_prog_len", 64'(prog_len), 64'd4);
        chk("first_ready", 64'(code_ready), 64'd1);
        chk("first_hold", 64'(cpu_hold), 64'd0);

        // Busy CPU: hold asserted, reads still forwarded until halted.
        cpu_halted = 1'b0;
        load_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_rd_en = 1'b1;
            cpu_rd_addr = AW'($urandom);
            tick();
        end
        cpu_rd_en = 1'b0;
        cpu_halted = 1'b1;
        tick();
        chk("gnt_after_halt", 64'(load_gnt), 64'd1);
        wr(5, DW'($urandom));
        load_req = 1'b0;
        wr(6, DW'($urandom));
        tick(); tick();
        chk("second_prog_len", 64'(prog_len), 64'd2);

        // Stray loader write while running.
        err_seen = 0; we_seen = 0;
        wr(7, DW'(64'h77));
        tick(); tick();
        chk("stray_err_cnt", 64'(err_seen), 64'd1);
        chk("stray_we_cnt", 64'(we_seen), 64'd0);

        // Empty load: back to NOPROG, prog_len kept, no pc_rst.
        pcrst_seen = 0;
        load_req = 1'b1;
        tick(); tick();
        load_req = 1'b0;
        tick(); tick(); tick();
        chk("empty_pcrst_cnt", 64'(pcrst_seen), 64'd0);
        chk("empty_ready", 64'(code_ready), 64'd0);
        chk("empty_prog_len", 64'(prog_len), 64'd2);

        // Reset in the middle of a load.
        load_req = 1'b1;
        tick();
        wr(0, DW'($urandom)); wr(1, DW'($urandom));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load_req = 1'b0;
        chk("rst_gnt", 64'(load_gnt), 64'd0);
        chk("rst_prog_len", 64'(prog_len), 64'd0);
        tick();

        // Saturating word count.
        load_req = 1'b1;
        tick();
        for (int i = 0; i < MAXW + 3; i++) wr(i % MAXW, DW'(i));
        load_req = 1'b0;
        tick(); tick();
        chk("sat_prog_len", 64'(prog_len), 64'(MAXW));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) load_req = ~load_req;
            load_wr_en   = ($urandom_range(0, 2) == 0);
            load_wr_addr = AW'($urandom);
            load_wr_data = {$urandom, $urandom};
            cpu_rd_en    = $urandom_range(0, 1) == 1;
            cpu_rd_addr  = AW'($urandom);
            cpu_halted   = ($urandom_range(0, 3) == 0);
            rst          = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
